apb_master_arbiter: RTL and testbench

Two-requester APB arbiter and sequencer that shares the single CPU-side APB port between the core control unit (master 0) and the debug/DMA port (master 1). It accepts a level request from each master, picks one round-robin, drives the APB setup/access phases, applies a timeout, and returns read data, ready and error to the winning master. It sits between the core and the APB interconnect, so the control unit's microcode no longer owns APB_psel directly.

---
 rtl/apb_master_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Two-master APB arbiter/sequencer: round-robin grant, setup/access sequencing,
// access-phase timeout, and per-master completion pulse with read data and error.
module apb_master_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SETUP_PHASE = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic              APB_PCLK,
  input  logic              APB_PRESET,

  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              m1_err,

  output logic              APB_psel,
  output logic              APB_penable,
  output logic              APB_pwrite,
  output logic [ADDR_W-1:0] APB_paddr,
  output logic [DATA_W-1:0] APB_pwdata,
  input  logic [DATA_W-1:0] APB_prdata,
  input  logic              APB_pready,
  input  logic              APB_perr,

  output logic              grant,
  output logic              busy
);

  localparam int              CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0]  TMO_LIMIT = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic                r_write;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic                r_m0_ready;
  logic                r_m1_ready;
  logic                r_m0_err;
  logic                r_m1_err;
  logic                r_grant;
  logic                r_last_served;
  logic                r_busy;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_any_req;
  logic                w_pick;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [CNT_W:0]      w_cnt_inc;
  logic                w_timeout;
  logic                w_finish;
  logic [DATA_W-1:0]   w_cap_rdata;
  logic                w_cap_err;

  // NOTE: every signal gets a value before any branch so no latch is inferred.
  always_comb begin
    w_any_req = m0_req | m1_req;
    if (m0_req && m1_req) begin
      w_pick = ~r_last_served;
    end else begin
      w_pick = m1_req;
    end
    w_sel_write = w_pick ? m1_write : m0_write;
    w_sel_addr  = w_pick ? m1_addr  : m0_addr;
    w_sel_wdata = w_pick ? m1_wdata : m0_wdata;

    // Extra bit on the increment so the compare against TIMEOUT never wraps.
    w_cnt_inc   = {1'b0, r_cnt} + (CNT_W + 1)'(1);
    w_timeout   = (TIMEOUT != 0) && !APB_pready && (w_cnt_inc == TMO_LIMIT);
    w_finish    = APB_pready | w_timeout;
    w_cap_err   = APB_pready ? APB_perr : 1'b1;
    w_cap_rdata = (APB_pready && !r_write) ? APB_prdata : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      r_state       <= S_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_write       <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_m0_rdata    <= '0;
      r_m1_rdata    <= '0;
      r_m0_ready    <= 1'b0;
      r_m1_ready    <= 1'b0;
      r_m0_err      <= 1'b0;
      r_m1_err      <= 1'b0;
      r_grant       <= 1'b0;
      r_last_served <= 1'b1;
      r_busy        <= 1'b0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant       <= w_pick;
            r_last_served <= w_pick;
            r_paddr       <= w_sel_addr;
            r_pwdata      <= w_sel_wdata;
            r_write       <= w_sel_write;
            r_pwrite      <= w_sel_write;
            r_psel        <= 1'b1;
            r_busy        <= 1'b1;
            r_cnt         <= '0;
            if (SETUP_PHASE != 0) begin
              r_state   <= S_SETUP;
              r_penable <= 1'b0;
            end else begin
              r_state   <= S_ACCESS;
              r_penable <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end

        S_ACCESS: begin
          if (w_finish) begin
            r_state   <= S_DONE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            if (r_grant) begin
              r_m1_ready <= 1'b1;
              r_m1_rdata <= w_cap_rdata;
              r_m1_err   <= w_cap_err;
            end else begin
              r_m0_ready <= 1'b1;
              r_m0_rdata <= w_cap_rdata;
              r_m0_err   <= w_cap_err;
            end
          end else begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
          end
        end

        S_DONE: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_m0_rdata <= '0;
          r_m1_rdata <= '0;
          r_m0_err   <= 1'b0;
          r_m1_err   <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign APB_psel    = r_psel;
  assign APB_penable = r_penable;
  assign APB_pwrite  = r_pwrite;
  assign APB_paddr   = r_paddr;
  assign APB_pwdata  = r_pwdata;
  assign m0_rdata    = r_m0_rdata;
  assign m1_rdata    = r_m1_rdata;
  assign m0_ready    = r_m0_ready;
  assign m1_ready    = r_m1_ready;
  assign m0_err      = r_m0_err;
  assign m1_err      = r_m1_err;
  assign grant       = r_grant;
  assign busy        = r_busy;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: address-driven APB slave model,
// per-master expected-response queues, directed and randomized traffic.
module tb_apb_master_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req   [2];
  logic          wr    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];

  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready, m0_err, m1_err;
  logic          psel, penable, pwrite, pready, perr, grant, busy;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_master_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .SETUP_PHASE(1), .TIMEOUT(TMO)
  ) dut (
    .APB_PCLK(clk), .APB_PRESET(rst),
    .m0_req(req[0]), .m0_write(wr[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_req(req[1]), .m1_write(wr[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .APB_psel(psel), .APB_penable(penable), .APB_pwrite(pwrite),
    .APB_paddr(paddr), .APB_pwdata(pwdata), .APB_prdata(prdata),
    .APB_pready(pready), .APB_perr(perr),
    .grant(grant), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave behaviour is a pure function of the address.
  function automatic logic [31:0] slv_data(input logic [31:0] a);
    if (a == 32'h1000) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
  endfunction
  function automatic bit slv_hang(input logic [31:0] a);
    return a[11:8] == 4'hF;
  endfunction
  function automatic bit slv_err(input logic [31:0] a);
    return a[11:8] == 4'hE;
  endfunction
  function automatic int slv_waits(input logic [31:0] a);
    return a[5] ? 3 : int'(a[3:2]);
  endfunction

  int slv_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) slv_cnt <= 0;
    else if (psel && penable && !pready) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
  end
  assign pready = psel && penable && !slv_hang(paddr) && (slv_cnt >= slv_waits(paddr));
  assign perr   = pready && slv_err(paddr);
  assign prdata = pready ? slv_data(paddr) : 32'hFFFF_FFFF;

  // Reference model: timeout yields err with zero data, writes return zero data.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   q_owner[$];
  int   ready_cnt [2];

  function automatic exp_t model(input logic w, input logic [31:0] a);
    exp_t e;
    if (slv_hang(a)) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else begin
      e.rdata = w ? 32'h0 : slv_data(a);
      e.err   = slv_err(a);
    end
    return e;
  endfunction

  task automatic push_exp(input int m, input exp_t e);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic logic rdy(input int m);
    return (m == 0) ? m0_ready : m1_ready;
  endfunction

  // Monitor: pops expectations whenever a master sees its ready pulse.
  exp_t          mon_e;
  logic          prev_psel, prev_pwrite;
  logic [AW-1:0] prev_paddr;
  logic [DW-1:0] prev_pwdata;

  always @(negedge clk) begin
    if (rst) begin
      prev_psel <= 1'b0;
    end else begin
      check("dual_ready", {m0_ready, m1_ready} == 2'b11, 0);
      if (m0_ready) begin
        ready_cnt[0] <= ready_cnt[0] + 1;
        if (q0.size() == 0) check("m0_spurious_ready", m0_ready, 0);
        else begin
          mon_e = q0.pop_front();
          check("m0_rdata", m0_rdata, mon_e.rdata);
          check("m0_err", m0_err, mon_e.err);
        end
        check("m1_quiet", {m1_rdata, m1_err}, 0);
      end
      if (m1_ready) begin
        ready_cnt[1] <= ready_cnt[1] + 1;
        if (q1.size() == 0) check("m1_spurious_ready", m1_ready, 0);
        else begin
          mon_e = q1.pop_front();
          check("m1_rdata", m1_rdata, mon_e.rdata);
          check("m1_err", m1_err, mon_e.err);
        end
        check("m0_quiet", {m0_rdata, m0_err}, 0);
      end
      if ((m0_ready || m1_ready) && q_owner.size() > 0)
        check("owner_order", m1_ready, q_owner.pop_front());

      check("pwrite_gated", pwrite & ~psel, 0);
      check("penable_gated", penable & ~psel, 0);
      if (psel && !prev_psel) begin
        check("owner_req", req[grant], 1);
        check("paddr_latch", paddr, addr[grant]);
        check("pwrite_latch", pwrite, wr[grant]);
        if (wr[grant]) check("pwdata_latch", pwdata, wdata[grant]);
      end
      if (psel && prev_psel)
        check("apb_stable", {paddr, pwdata, pwrite} == {prev_paddr, prev_pwdata, prev_pwrite}, 1);
      prev_psel   <= psel;
      prev_paddr  <= paddr;
      prev_pwdata <= pwdata;
      prev_pwrite <= pwrite;
    end
  end

  // Call at a negedge; returns at the negedge where ready is seen.
  task automatic xfer(input int m, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input bit keep);
    bit got = 0;
    push_exp(m, model(w, a));
    wr[m] = w; addr[m] = a; wdata[m] = d; req[m] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rdy(m)) begin got = 1; break; end
    end
    check($sformatf("m%0d_ready_wait", m), got, 1);
    if (!keep) req[m] = 1'b0;
  endtask

  // Counts negedges from request to ready (k == edge k) and access cycles.
  task automatic measure(input int m, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int pen);
    lat = -1; pen = 0;
    push_exp(m, model(w, a));
    wr[m] = w; addr[m] = a; wdata[m] = d; req[m] = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (penable) pen++;
      if (psel) check("measure_pwrite", pwrite, w);
      if (rdy(m)) begin lat = c; break; end
    end
    req[m] = 1'b0;
  endtask

  task automatic rand_master(input int m, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = $urandom;
      a[31:16] = '0;
      if (a[11:8] == 4'hF && $urandom_range(0, 3) != 0) a[11:8] = 4'h3;
      xfer(m, 1'($urandom_range(0, 1)), a, $urandom, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, pen, base0, base1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; wr[i] = 0; addr[i] = '0; wdata[i] = '0; ready_cnt[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {psel, penable, pwrite, grant, busy, m0_ready, m1_ready, m0_err, m1_err}, 0);
    check("reset_apb_bus", {paddr, pwdata}, 0);
    check("reset_rdata", {m0_rdata, m1_rdata}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single zero-wait read by master 0.
    push_exp(0, model(0, 32'h1000));
    wr[0] = 0; addr[0] = 32'h1000; req[0] = 1'b1;
    @(negedge clk); check("t1_setup", {psel, penable, busy, grant}, 4'b1010);
    @(negedge clk); check("t1_access", {psel, penable}, 2'b11);
    @(negedge clk); check("t1_ready", {m0_ready, psel}, 2'b10);
    req[0] = 1'b0;
    @(negedge clk); check("t1_idle", {psel, busy, m0_ready}, 0);

    // Write with three wait states by master 1.
    measure(1, 1, 32'h20, 32'h55, lat, pen);
    check("t2_latency", lat, 6);
    check("t2_access_cycles", pen, 4);
    check("t2_grant", grant, 1);
    @(negedge clk);

    // Timeout with a slave that never answers.
    measure(0, 0, 32'hF00, 32'h0, lat, pen);
    check("t3_latency", lat, 10);
    check("t3_access_cycles", pen, TMO);
    check("t3_psel_done", psel, 0);
    @(negedge clk); check("t3_psel_after", {psel, penable}, 0);

    // Slave error together with pready.
    measure(1, 0, 32'hE04, 32'h0, lat, pen);
    check("t4_latency", lat, 4);
    @(negedge clk);

    // Reset in the middle of an access by master 0.
    push_exp(0, model(0, 32'hF10));
    wr[0] = 0; addr[0] = 32'hF10; req[0] = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_in_access", {psel, penable}, 2'b11);
    #2 rst = 1'b1;
    #1 check("t5_async_drop", {psel, penable, busy}, 0);
    q0.delete();
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_ready", {m0_ready, m1_ready, psel}, 0);
    end

    // Continuous contention after reset: master 0 wins the first tie.
    base0 = ready_cnt[0];
    base1 = ready_cnt[1];
    q_owner = '{0, 1, 0, 1};
    fork
      begin
        xfer(0, 0, 32'h100, 32'h0, 1);
        xfer(0, 1, 32'h104, 32'hA5A5_0001, 0);
      end
      begin
        xfer(1, 1, 32'h200, 32'h1234_5678, 1);
        xfer(1, 0, 32'h208, 32'h0, 0);
      end
    join
    @(negedge clk);
    check("t6_owner_seq_done", q_owner.size(), 0);
    check("t6_m0_pulses", ready_cnt[0] - base0, 2);
    check("t6_m1_pulses", ready_cnt[1] - base1, 2);

    // Randomized traffic from both masters.
    fork
      rand_master(0, 25);
      rand_master(1, 25);
    join
    repeat (5) @(negedge clk);
    check("sb_drain_m0", q0.size(), 0);
    check("sb_drain_m1", q1.size(), 0);
    check("final_idle", {psel, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
